// File: rtl/excess3_digit_rx.sv
// Bit-serial Excess-3 digit receiver: assembles LSB-first 4-bit codes, drops
// illegal ones, and buffers up to two legal codes behind a valid/ready port.
module excess3_digit_rx #(
  parameter int ERRW = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            SIN,
  input  logic            SVALID,
  input  logic            SYNC,
  output logic [3:0]      OT,
  output logic            OVALID,
  input  logic            ORDY,
  output logic            ERR,
  output logic            OVF,
  output logic [ERRW-1:0] ERRCNT
);

  localparam logic [ERRW-1:0] ERRCNT_ONE = {{(ERRW-1){1'b0}}, 1'b1};
  localparam logic [3:0]      XS3_ZERO   = 4'b0011;

  // Assembler state
  logic [2:0] shr;
  logic [1:0] bcnt;

  // FIFO state
  logic [3:0] mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;

  logic       take_last;
  logic [3:0] cand;
  logic       legal;
  logic       pop;
  logic       push;
  logic       err_next;
  logic       ovf_next;

  // SYNC forces the current bit to position 0, so it can never complete a code.
  assign take_last = SVALID && !SYNC && (bcnt == 2'd3);
  assign cand      = {SIN, shr};
  assign legal     = (cand >= 4'd3) && (cand <= 4'd12);
  assign pop       = OVALID && ORDY;
  assign push      = take_last && legal && ((count != 2'd2) || pop);
  assign ovf_next  = take_last && legal && (count == 2'd2) && !pop;
  assign err_next  = take_last && !legal;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shr  <= 3'd0;
      bcnt <= 2'd0;
    end else if (SVALID) begin
      if (take_last) begin
        bcnt <= 2'd0;
      end else begin
        shr  <= {SIN, shr[2:1]};
        bcnt <= SYNC ? 2'd1 : bcnt + 2'd1;
      end
    end
  end

  // Storage carries no reset; the empty condition masks stale contents.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= cand;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ERR    <= 1'b0;
      OVF    <= 1'b0;
      ERRCNT <= '0;
    end else begin
      ERR <= err_next;
      OVF <= ovf_next;
      if (err_next && (ERRCNT != {ERRW{1'b1}})) begin
        ERRCNT <= ERRCNT + ERRCNT_ONE;
      end
    end
  end

  assign OVALID = (count != 2'd0);
  assign OT     = OVALID ? mem[rd_ptr] : XS3_ZERO;

endmodule

// File: tb/tb_excess3_digit_rx.sv
// Randomized and directed bench for excess3_digit_rx against a queue-based
// reference model of digit assembly, legality checks and the 2-deep buffer.
module tb_excess3_digit_rx;

  logic       CLK = 1'b0;
  logic       RST;
  logic       SIN;
  logic       SVALID;
  logic       SYNC;
  logic       ORDY;
  logic [3:0] OT, OT2;
  logic       OVALID, OVALID2;
  logic       ERR, ERR2;
  logic       OVF, OVF2;
  logic [7:0] ERRCNT;
  logic [1:0] ERRCNT2;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [3:0] m_fifo[$];
  logic       m_bits[$];
  logic       m_err;
  logic       m_ovf;
  int         m_errs;

  excess3_digit_rx #(.ERRW(8)) dut (
    .CLK(CLK), .RST(RST), .SIN(SIN), .SVALID(SVALID), .SYNC(SYNC),
    .OT(OT), .OVALID(OVALID), .ORDY(ORDY), .ERR(ERR), .OVF(OVF), .ERRCNT(ERRCNT)
  );

  excess3_digit_rx #(.ERRW(2)) dut_w2 (
    .CLK(CLK), .RST(RST), .SIN(SIN), .SVALID(SVALID), .SYNC(SYNC),
    .OT(OT2), .OVALID(OVALID2), .ORDY(ORDY), .ERR(ERR2), .OVF(OVF2), .ERRCNT(ERRCNT2)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] exp_ot();
    return (m_fifo.size() > 0) ? m_fifo[0] : 4'd3;
  endfunction

  function automatic logic exp_v();
    return m_fifo.size() > 0;
  endfunction

  function automatic logic [7:0] exp_cnt8();
    return (m_errs > 255) ? 8'd255 : 8'(m_errs);
  endfunction

  function automatic logic [1:0] exp_cnt2();
    return (m_errs > 3) ? 2'd3 : 2'(m_errs);
  endfunction

  function automatic void model_reset();
    m_fifo.delete();
    m_bits.delete();
    m_err  = 1'b0;
    m_ovf  = 1'b0;
    m_errs = 0;
  endfunction

  // One rising edge of the reference behaviour.
  function automatic void model_step(logic sin, logic svalid, logic sync, logic ordy);
    int code;
    m_err = 1'b0;
    m_ovf = 1'b0;
    if (m_fifo.size() > 0 && ordy) void'(m_fifo.pop_front());
    if (svalid) begin
      if (sync) m_bits.delete();
      m_bits.push_back(sin);
      if (m_bits.size() == 4) begin
        code = 0;
        for (int i = 0; i < 4; i++) code += int'(m_bits[i]) << i;
        m_bits.delete();
        if (code >= 3 && code <= 12) begin
          if (m_fifo.size() < 2) m_fifo.push_back(4'(code));
          else m_ovf = 1'b1;
        end else begin
          m_err = 1'b1;
          m_errs++;
        end
      end
    end
  endfunction

  task automatic tick(input logic sin, input logic svalid, input logic sync, input logic ordy);
    SIN = sin; SVALID = svalid; SYNC = sync; ORDY = ordy;
    @(posedge CLK);
    model_step(sin, svalid, sync, ordy);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; SIN = 1'b0; SVALID = 1'b0; SYNC = 1'b0; ORDY = 1'b0;
    model_reset();
    #12;
    checks++;
    if ({OT, OVALID, ERR, OVF, ERRCNT, ERRCNT2} !== {4'b0011, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0}) begin
      failures++;
      $display("FAIL reset_values: got OT=%h OVALID=%b ERR=%b OVF=%b ERRCNT=%0d required OT=3 OVALID=0 ERR=0 OVF=0 ERRCNT=0",
               OT, OVALID, ERR, OVF, ERRCNT);
    end
    #1 RST = 1'b0;
    #4;
  endtask

  task automatic test_legal_stream();
    logic [3:0] cv;
    for (int c = 3; c <= 12; c++) begin
      cv = 4'(c);
      for (int b = 0; b < 4; b++) begin
        tick(cv[b], 1'b1, 1'b0, 1'b1);
        checks++;
        if ({OT, OVALID, ERR, OVF} !== {exp_ot(), exp_v(), m_err, m_ovf}) begin
          failures++;
          $display("FAIL legal_stream code=%0d bit=%0d: got OT=%h OVALID=%b ERR=%b OVF=%b required OT=%h OVALID=%b ERR=%b OVF=%b",
                   c, b, OT, OVALID, ERR, OVF, exp_ot(), exp_v(), m_err, m_ovf);
        end
        if (b == 3) begin
          checks++;
          if (OT !== cv || OVALID !== 1'b1) begin
            failures++;
            $display("FAIL legal_latency: got OT=%h OVALID=%b required OT=%h OVALID=1", OT, OVALID, cv);
          end
        end
      end
    end
  endtask

  task automatic test_illegal();
    logic [3:0] codes [5];
    logic [3:0] cv;
    codes = '{4'd0, 4'd2, 4'd13, 4'd15, 4'd14};
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      cv = codes[k];
      for (int b = 0; b < 4; b++) begin
        tick(cv[b], 1'b1, 1'b0, 1'b1);
        checks++;
        if ({OT, OVALID, ERR, OVF} !== {4'b0011, 1'b0, b == 3, 1'b0}) begin
          failures++;
          $display("FAIL illegal code=%0d bit=%0d: got OT=%h OVALID=%b ERR=%b OVF=%b required OT=3 OVALID=0 ERR=%b OVF=0",
                   cv, b, OT, OVALID, ERR, OVF, b == 3);
        end
      end
      if (k == 3) begin
        checks++;
        if (ERRCNT !== 8'd4 || ERRCNT2 !== 2'd3) begin
          failures++;
          $display("FAIL errcnt_four: got ERRCNT=%0d ERRCNT_w2=%0d required 4 and 3", ERRCNT, ERRCNT2);
        end
      end
    end
    checks++;
    if (ERRCNT !== 8'd5 || ERRCNT2 !== 2'd3) begin
      failures++;
      $display("FAIL errcnt_saturate: got ERRCNT=%0d ERRCNT_w2=%0d required 5 and 3", ERRCNT, ERRCNT2);
    end
  endtask

  task automatic test_backpressure_ovf();
    logic [3:0] codes [3];
    logic [3:0] cv;
    logic [3:0] deliv[$];
    codes = '{4'd7, 4'd8, 4'd9};
    for (int k = 0; k < 3; k++) begin
      cv = codes[k];
      for (int b = 0; b < 4; b++) begin
        tick(cv[b], 1'b1, 1'b0, 1'b0);
        checks++;
        if ({OT, OVALID, ERR, OVF} !== {exp_ot(), exp_v(), m_err, m_ovf}) begin
          failures++;
          $display("FAIL backpressure code=%0d bit=%0d: got OT=%h OVALID=%b ERR=%b OVF=%b required OT=%h OVALID=%b ERR=%b OVF=%b",
                   cv, b, OT, OVALID, ERR, OVF, exp_ot(), exp_v(), m_err, m_ovf);
        end
      end
    end
    checks++;
    if (OVF !== 1'b1 || OT !== 4'd7 || OVALID !== 1'b1) begin
      failures++;
      $display("FAIL ovf_pulse: got OVF=%b OT=%h OVALID=%b required OVF=1 OT=7 OVALID=1", OVF, OT, OVALID);
    end
    for (int i = 0; i < 3; i++) begin
      if (OVALID) deliv.push_back(OT);
      tick(1'b0, 1'b0, 1'b0, 1'b1);
    end
    checks++;
    if (deliv.size() != 2 || deliv[0] !== 4'd7 || deliv[1] !== 4'd8 || OVALID !== 1'b0 || OVF !== 1'b0) begin
      failures++;
      $display("FAIL drain_after_ovf: got %0d items first=%h second=%h OVALID=%b required 2 items 7,8 OVALID=0",
               deliv.size(), (deliv.size() > 0) ? deliv[0] : 4'hx, (deliv.size() > 1) ? deliv[1] : 4'hx, OVALID);
    end
  endtask

  task automatic test_full_with_pop();
    logic [3:0] codes [3];
    logic [3:0] cv;
    logic [3:0] deliv[$];
    logic       rdy;
    codes = '{4'd7, 4'd8, 4'd9};
    for (int k = 0; k < 3; k++) begin
      cv = codes[k];
      for (int b = 0; b < 4; b++) begin
        rdy = (k == 2 && b == 3);
        if (rdy && OVALID) deliv.push_back(OT);
        tick(cv[b], 1'b1, 1'b0, rdy);
        checks++;
        if ({OT, OVALID, ERR, OVF} !== {exp_ot(), exp_v(), m_err, m_ovf}) begin
          failures++;
          $display("FAIL full_with_pop code=%0d bit=%0d: got OT=%h OVALID=%b ERR=%b OVF=%b required OT=%h OVALID=%b ERR=%b OVF=%b",
                   cv, b, OT, OVALID, ERR, OVF, exp_ot(), exp_v(), m_err, m_ovf);
        end
      end
    end
    checks++;
    if (OVF !== 1'b0 || OT !== 4'd8) begin
      failures++;
      $display("FAIL no_ovf_on_pop: got OVF=%b OT=%h required OVF=0 OT=8", OVF, OT);
    end
    for (int i = 0; i < 3; i++) begin
      if (OVALID) deliv.push_back(OT);
      tick(1'b0, 1'b0, 1'b0, 1'b1);
    end
    checks++;
    if (deliv.size() != 3 || deliv[0] !== 4'd7 || deliv[1] !== 4'd8 || deliv[2] !== 4'd9) begin
      failures++;
      $display("FAIL full_pop_order: got %0d items required 3 items 7,8,9", deliv.size());
    end
  endtask

  task automatic test_sync_resync();
    logic [3:0] cv;
    int         err_seen;
    cv = 4'd6;
    err_seen = 0;
    tick(1'b1, 1'b1, 1'b0, 1'b1);
    tick(1'b1, 1'b1, 1'b0, 1'b1);
    for (int b = 0; b < 4; b++) begin
      tick(cv[b], 1'b1, b == 0, 1'b0);
      if (ERR !== 1'b0) err_seen++;
      checks++;
      if ({OT, OVALID, ERR, OVF} !== {exp_ot(), exp_v(), m_err, m_ovf}) begin
        failures++;
        $display("FAIL sync_resync bit=%0d: got OT=%h OVALID=%b ERR=%b OVF=%b required OT=%h OVALID=%b ERR=%b OVF=%b",
                 b, OT, OVALID, ERR, OVF, exp_ot(), exp_v(), m_err, m_ovf);
      end
    end
    checks++;
    if (OT !== 4'd6 || OVALID !== 1'b1 || err_seen != 0 || ERRCNT !== 8'd5) begin
      failures++;
      $display("FAIL sync_only_six: got OT=%h OVALID=%b err_pulses=%0d ERRCNT=%0d required OT=6 OVALID=1 err_pulses=0 ERRCNT=5",
               OT, OVALID, err_seen, ERRCNT);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_async_reset();
    logic [3:0] codes [2];
    logic [3:0] cv;
    codes = '{4'd7, 4'd8};
    for (int k = 0; k < 2; k++) begin
      cv = codes[k];
      for (int b = 0; b < 4; b++) tick(cv[b], 1'b1, 1'b0, 1'b0);
    end
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (OVALID !== 1'b1 || OT !== 4'd7) begin
      failures++;
      $display("FAIL pre_reset_buffered: got OT=%h OVALID=%b required OT=7 OVALID=1", OT, OVALID);
    end
    SVALID = 1'b0;
    #3 RST = 1'b1;
    #1;
    checks++;
    if ({OT, OVALID, ERR, OVF, ERRCNT} !== {4'b0011, 1'b0, 1'b0, 1'b0, 8'd0}) begin
      failures++;
      $display("FAIL async_reset: got OT=%h OVALID=%b ERR=%b OVF=%b ERRCNT=%0d required OT=3 OVALID=0 ERR=0 OVF=0 ERRCNT=0",
               OT, OVALID, ERR, OVF, ERRCNT);
    end
    #2 RST = 1'b0;
    model_reset();
    cv = 4'd5;
    for (int b = 0; b < 4; b++) begin
      tick(cv[b], 1'b1, 1'b0, 1'b0);
      checks++;
      if ({OT, OVALID, ERR, OVF} !== {exp_ot(), exp_v(), m_err, m_ovf}) begin
        failures++;
        $display("FAIL post_reset bit=%0d: got OT=%h OVALID=%b ERR=%b OVF=%b required OT=%h OVALID=%b ERR=%b OVF=%b",
                 b, OT, OVALID, ERR, OVF, exp_ot(), exp_v(), m_err, m_ovf);
      end
    end
    checks++;
    if (OT !== 4'd5 || OVALID !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_five: got OT=%h OVALID=%b required OT=5 OVALID=1", OT, OVALID);
    end
  endtask

  task automatic test_random();
    logic sin, sv, sy, rdy;
    for (int i = 0; i < 600; i++) begin
      sin = 1'($urandom_range(0, 1));
      sv  = ($urandom_range(0, 9) != 0);
      sy  = ($urandom_range(0, 15) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      tick(sin, sv, sy, rdy);
      checks++;
      if ({OT, OVALID, ERR, OVF, ERRCNT, ERRCNT2} !== {exp_ot(), exp_v(), m_err, m_ovf, exp_cnt8(), exp_cnt2()}) begin
        failures++;
        $display("FAIL random i=%0d: got OT=%h OVALID=%b ERR=%b OVF=%b ERRCNT=%0d/%0d required OT=%h OVALID=%b ERR=%b OVF=%b ERRCNT=%0d/%0d",
                 i, OT, OVALID, ERR, OVF, ERRCNT, ERRCNT2,
                 exp_ot(), exp_v(), m_err, m_ovf, exp_cnt8(), exp_cnt2());
      end
    end
  endtask

  initial begin
    test_reset();
    test_legal_stream();
    test_illegal();
    test_backpressure_ovf();
    test_full_with_pop();
    test_sync_resync();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
